// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the programmable clock divider
package clk_div_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int MIN_RATIO = 2;

    // Length of the high phase, in source cycles, for ratio n.
    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_odd_ext.sv
// rtl/clk_div_odd_ext.sv - half-cycle extension of the divided clock high phase for odd ratios
module clk_div_odd_ext (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_en,
    input  logic i_odd,
    input  logic i_clk_rise,
    output logic o_clk
);

    logic neg_q;

    // Captures the rising-edge clock on the falling edge, so the OR below
    // keeps o_clk high for an extra half source cycle after each fall.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            neg_q <= 1'b0;
        end else if (i_clk_en) begin
            neg_q <= i_clk_rise;
        end
    end

    assign o_clk = i_clk_rise | (neg_q & i_odd);

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with glitch-free ratio updates
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEFAULT_RATIO = 8,
    parameter int ODD_50        = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_ratio,
    input  logic             i_ratio_vld,
    output logic             o_ratio_ack,
    output logic             o_ratio_err,
    output logic [WIDTH-1:0] o_ratio_cur,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] DEF_R = WIDTH'(DEFAULT_RATIO);

    if (DEFAULT_RATIO < MIN_RATIO || DEFAULT_RATIO > (2**WIDTH) - 1) begin : g_bad_default
        $error("clk_div_prog: DEFAULT_RATIO out of range");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] ratio_sel;
    logic [WIDTH-1:0] half_sel;
    logic [WIDTH-1:0] cnt_nxt;
    logic             boundary;
    logic             req_ok;
    logic             clk_q;
    logic             tick_q;
    logic             ack_q;
    logic             err_q;
    logic             run_q;

    // A counter value of zero on an enabled edge marks a period boundary;
    // an accepted ratio already governs the period that starts there.
    always_comb begin
        boundary  = i_clk_en && (cnt_q == '0);
        req_ok    = i_ratio >= WIDTH'(MIN_RATIO);
        ratio_sel = ratio_q;
        if (boundary && i_ratio_vld && req_ok) begin
            ratio_sel = i_ratio;
        end
        half_sel = WIDTH'(half(32'(ratio_sel)));
        cnt_nxt  = (cnt_q == ratio_sel - 1'b1) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            ratio_q <= DEF_R;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            run_q  <= 1'b1;
            if (i_clk_en) begin
                cnt_q   <= cnt_nxt;
                ratio_q <= ratio_sel;
                clk_q   <= cnt_q < half_sel;
                tick_q  <= boundary;
                if (boundary && i_ratio_vld) begin
                    ack_q <= 1'b1;
                    err_q <= !req_ok;
                end
            end
        end
    end

    // run_q masks a stale extension in the half cycle after a reset edge.
    if (ODD_50 != 0) begin : g_odd
        clk_div_odd_ext u_odd_ext (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_clk_en   (i_clk_en),
            .i_odd      (ratio_q[0] & run_q),
            .i_clk_rise (clk_q),
            .o_clk      (o_clk)
        );
    end else begin : g_even
        assign o_clk = clk_q;
    end

    assign o_tick      = tick_q;
    assign o_ratio_ack = ack_q;
    assign o_ratio_err = err_q;
    assign o_ratio_cur = ratio_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider. It is the parametrised successor to the fixed-RATIO divider.
- Divides i_clk by a ratio N that can change at runtime.
- Odd ratios can optionally have a true 50% duty cycle.
- A valid/ack handshake carries ratio updates; each update takes effect only at a period boundary, so the output never glitches.
- Sits in the clock-generation area. Drives divided clocks and a same-domain tick enable for downstream logic.

Parameters:
- WIDTH, 8, bit width of the ratio and the internal counter.
- DEFAULT_RATIO, 8, active ratio after reset. Must lie in [2, 2^WIDTH-1]; elaboration check.
- ODD_50, 1, 1 = odd ratios get exact 50% duty (uses a falling-edge flop); 0 = odd ratios use rising-edge logic only.

Ports:
- i_clk, in, 1, source clock. Sole clock domain.
- i_rst, in, 1, reset. Synchronous, active-high.
- i_clk_en, in, 1, count enable. Low freezes the divider.
- i_ratio, in, WIDTH, requested division ratio N.
- i_ratio_vld, in, 1, ratio request valid. Held high until o_ratio_ack.
- o_ratio_ack, out, 1, one-cycle pulse: request consumed.
- o_ratio_err, out, 1, one-cycle pulse together with ack when the request was rejected (N<2).
- o_ratio_cur, out, WIDTH, currently active ratio.
- o_clk, out, 1, divided clock.
- o_tick, out, 1, one-cycle pulse marking each o_clk rising edge.

Behaviour:
Reset (edge with i_rst=1):
- counter=0, active ratio=DEFAULT_RATIO, o_clk=0, o_tick=0, o_ratio_ack=0, o_ratio_err=0, o_ratio_cur=DEFAULT_RATIO.
- The falling-edge flop also clears.

Period:
- Let H = N>>1.
- Boundary edge = first rising edge with i_rst=0 and i_clk_en=1 after reset, and every N enabled edges after that.
- At a boundary edge, o_clk rises and o_tick=1 for that one cycle.
- o_clk is high for H enabled cycles, then low for N-H.
- ODD_50=1 with odd N: the fall is delayed half a cycle by the falling-edge flop, giving high = low = N/2 periods. Even N is unaffected.

Ratio update:
- i_ratio is sampled only at a boundary edge, and only if i_ratio_vld=1.
- If N>=2: the new ratio governs the period starting at that edge, and o_ratio_cur updates on the same edge.
- If N<2: the active ratio is unchanged and o_ratio_err pulses.
- o_ratio_ack pulses in the cycle after the sampling edge, coincident with o_tick.
- The requester must hold i_ratio stable while vld is high, and drop vld on the edge after ack.
- No double accept is possible, because the next boundary is at least 2 edges away.
- vld arriving mid-period waits for the next boundary. The current period always completes at the old ratio.

Enable:
- i_clk_en=0 freezes the counter, o_clk level and the falling-edge flop.
- o_tick=0 while frozen, and no ratio is sampled.
- Resuming continues mid-period.

Boundary cases:
- Reset mid-operation truncates the current o_clk phase; this is permitted.
- An in-flight request is dropped with no ack; the requester re-issues it.
- N = 2^WIDTH-1: the counter must not overflow.
- N = 2: o_clk toggles every cycle and o_tick is high in every other cycle.

Decomposition:
- Package clk_div_pkg holds: the WIDTH default, the MIN_RATIO=2 constant, and a half(N) function.
- One sub-module, clk_div_odd_ext: falling-edge flop plus OR stage implementing the ODD_50 extension. Instantiated only when ODD_50=1.

Test Plan (CLK_PERIOD=10):
1. Reset, then release with i_clk_en=1, DEFAULT_RATIO=8 -> o_clk period 80 ns, high 40 ns; o_tick every 8th cycle; o_ratio_cur=8.
2. Request N=5 -> ODD_50=0: high 20 ns / low 30 ns. ODD_50=1: high 25 ns / low 25 ns.
3. Request 8->3 asserted 2 cycles into a period -> that period stays 80 ns; new 30 ns period starts at the next boundary; ack and o_tick coincide; o_ratio_cur=3.
4. Request N=1, then N=0 -> each gives an ack+err pulse; period stays at the prior ratio.
5. i_clk_en low for 5 cycles during a high phase -> high phase stretches to 90 ns (N=8); no o_tick while low.
6. i_rst pulsed while vld is pending -> no ack; o_clk=0; o_ratio_cur=8. Also run N=255 and N=2 for an extremes check.
